// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: default fetch widths, reset PC and the NOP encoding
// used by instr_fetch_unit, splitInstruction and programMips.
package mips_pkg;

    localparam int unsigned MIPS_ADDR_W   = 5;
    localparam int unsigned MIPS_DATA_W   = 32;
    localparam int unsigned MIPS_RESET_PC = 0;
    localparam logic [31:0] MIPS_NOP      = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory read port, redirect/halt control from FSM_Mips,
// and the valid/ready instruction stream to decode.
interface instr_fetch_unit_if
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W = MIPS_ADDR_W,
    parameter int unsigned DATA_W = MIPS_DATA_W
) ();

    logic              imem_rd_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_data;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              halted;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_rd_en, imem_addr, halted, out_valid, out_instr, out_pc,
        input  imem_data, redirect_valid, redirect_pc, halt, out_ready
    );

    modport slave (
        input  imem_rd_en, imem_addr, halted, out_valid, out_instr, out_pc,
        output imem_data, redirect_valid, redirect_pc, halt, out_ready
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_buf.sv
// Two-entry FIFO of {pc, instr} words between instruction memory and decode.
// Entry 0 is always the head; flush empties the queue in one cycle.
module instr_fetch_unit_fetch_buf #(
    parameter int unsigned W = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] e0;
    logic [W-1:0] e1;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) e0 <= din;
                    else               e1 <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    e0    <= e1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // simultaneous push/pop: the new word lands behind whatever remains
                    if (count == 2'd1) begin
                        e0 <= din;
                    end else begin
                        e0 <= e1;
                        e1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid = (count != 2'd0);
    assign dout  = valid ? e0 : '0;

    overflow_a: assert property (@(posedge clk) disable iff (rst || flush)
        !(push && !pop && count == 2'd2));

endmodule

// File: rtl/instr_fetch_unit.sv
// MIPS instruction fetch stage: owns the PC, issues 1-cycle-latency reads to programMips
// and queues returned words for decode, honouring redirects and halt.
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W   = MIPS_ADDR_W,
    parameter int unsigned DATA_W   = MIPS_DATA_W,
    parameter int unsigned RESET_PC = MIPS_RESET_PC
) (
    input  logic               clock,
    input  logic               reset,
    instr_fetch_unit_if.master bus
);

    logic [ADDR_W-1:0]        pc;
    logic [ADDR_W-1:0]        pc_q;
    logic                     inflight;
    logic                     stale;
    logic                     issue;
    logic                     push;
    logic                     pop;
    logic                     buf_valid;
    logic [1:0]               count;
    logic [2:0]               occupancy;
    logic [ADDR_W+DATA_W-1:0] head;

    assign pop       = buf_valid & bus.out_ready;
    assign occupancy = {1'b0, count} + {2'b00, inflight};
    // credit: a slot freed by this cycle's pop may be reused by this cycle's issue
    assign issue     = !reset && !bus.halt && !bus.redirect_valid
                       && (occupancy < 3'd2 + {2'b00, pop});
    assign push      = !reset && inflight && !stale && !bus.redirect_valid;

    always_ff @(posedge clock) begin
        if (reset) begin
            pc       <= ADDR_W'(RESET_PC);
            pc_q     <= '0;
            inflight <= 1'b0;
            stale    <= 1'b0;
        end else begin
            inflight <= issue;
            stale    <= bus.redirect_valid & inflight;
            if (issue) pc_q <= pc;
            if (bus.redirect_valid) pc <= bus.redirect_pc;
            else if (issue)         pc <= pc + ADDR_W'(1);
        end
    end

    instr_fetch_unit_fetch_buf #(
        .W (ADDR_W + DATA_W)
    ) u_fetch_buf (
        .clk   (clock),
        .rst   (reset),
        .flush (bus.redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({pc_q, bus.imem_data}),
        .valid (buf_valid),
        .dout  (head),
        .count (count)
    );

    assign bus.imem_rd_en = issue;
    assign bus.imem_addr  = issue ? pc : '0;
    assign bus.out_valid  = buf_valid;
    assign bus.out_pc     = head[ADDR_W+DATA_W-1:DATA_W];
    assign bus.out_instr  = buf_valid ? head[DATA_W-1:0] : DATA_W'(MIPS_NOP);
    assign bus.halted     = bus.halt && !inflight && (count == 2'd0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model checked every cycle, directed
// scenarios pinned with literal expectations, then randomized ready/halt/redirect/reset.
module tb_instr_fetch_unit;
    import mips_pkg::*;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    instr_fetch_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .RESET_PC (0)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [DW-1:0] mem [32];
    initial for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);

    always @(posedge clock) if (bus.imem_rd_en) bus.imem_data <= mem[bus.imem_addr];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: queue of delivered words plus at most one outstanding read.
    logic [AW+DW-1:0] q[$];
    bit               pend = 1'b0;
    logic [AW-1:0]    ppc  = '0;
    logic [AW-1:0]    mpc  = '0;

    always @(negedge clock) begin
        bit            ev, epop, eiss, ehalt;
        logic [AW-1:0] epc;
        logic [DW-1:0] ein;
        int            occ;
        ev  = (q.size() > 0);
        epc = '0;
        ein = '0;
        if (ev) {epc, ein} = q[0];
        epop  = ev && bus.out_ready;
        occ   = q.size() + (pend ? 1 : 0) - (epop ? 1 : 0);
        eiss  = !reset && !bus.halt && !bus.redirect_valid && (occ < 2);
        ehalt = bus.halt && !pend && (q.size() == 0);
        chk("m_out_valid",  bus.out_valid,  ev);
        chk("m_out_pc",     bus.out_pc,     epc);
        chk("m_out_instr",  bus.out_instr,  ein);
        chk("m_imem_rd_en", bus.imem_rd_en, eiss);
        chk("m_halted",     bus.halted,     ehalt);
        if (eiss) chk("m_imem_addr", bus.imem_addr, mpc);

        if (reset) begin
            q.delete();
            pend = 1'b0;
            mpc  = '0;
        end else if (bus.redirect_valid) begin
            q.delete();
            pend = 1'b0;
            mpc  = bus.redirect_pc;
        end else begin
            if (epop) void'(q.pop_front());
            if (pend) q.push_back({ppc, mem[ppc]});
            pend = eiss;
            if (eiss) begin
                ppc = mpc;
                mpc = mpc + 5'd1;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic go();
        step();
        @(negedge clock);
    endtask

    // Leaves the bench at the start of cycle 0 (first cycle after reset release).
    task automatic start(input bit rdy);
        reset              = 1'b1;
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = rdy;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset              = 1'b1;
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.out_ready      = 1'b1;

        // streaming with wrap at pc 31
        start(1'b1);
        for (int k = 0; k < 36; k++) begin
            @(negedge clock);
            if (k == 0) begin
                chk("t1_rd_en_c0", bus.imem_rd_en, 1);
                chk("t1_addr_c0",  bus.imem_addr,  0);
                chk("t1_valid_c0", bus.out_valid,  0);
            end
            if (k == 2) begin
                chk("t1_valid_c2", bus.out_valid, 1);
                chk("t1_pc_c2",    bus.out_pc,    0);
                chk("t1_instr_c2", bus.out_instr, 32'h1000_0000);
            end
            if (k == 3) chk("t1_pc_c3", bus.out_pc, 1);
            if (k == 32) begin
                chk("t3_rd_en_wrap", bus.imem_rd_en, 1);
                chk("t3_addr_wrap",  bus.imem_addr,  0);
            end
            if (k == 33) begin
                chk("t3_pc31",    bus.out_pc,    31);
                chk("t3_instr31", bus.out_instr, 32'h1000_001f);
            end
            if (k == 34) chk("t3_pc0_after_wrap", bus.out_pc, 0);
            step();
        end

        // backpressure
        start(1'b0);
        @(negedge clock);
        go();
        chk("t2_addr_c1", bus.imem_addr, 1);
        go();
        chk("t2_rd_en_c2", bus.imem_rd_en, 0);
        go();
        chk("t2_rd_en_c3", bus.imem_rd_en, 0);
        chk("t2_hold_pc",  bus.out_pc,     0);
        chk("t2_hold_ins", bus.out_instr,  32'h1000_0000);
        step();
        bus.out_ready = 1'b1;
        @(negedge clock);
        chk("t2_pc_c4",   bus.out_pc,    0);
        chk("t2_addr_c4", bus.imem_addr, 2);
        go();
        chk("t2_pc_c5", bus.out_pc, 1);
        go();
        chk("t2_pc_c6", bus.out_pc, 2);
        go();
        chk("t2_pc_c7", bus.out_pc, 3);

        // redirect with one queued and one outstanding read
        start(1'b0);
        @(negedge clock);
        go();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 5'd5;
        @(negedge clock);
        chk("t4_rd_en_R", bus.imem_rd_en, 0);
        step();
        bus.redirect_valid = 1'b0;
        @(negedge clock);
        chk("t4_valid_R1", bus.out_valid,  0);
        chk("t4_addr_R1",  bus.imem_addr,  5);
        go();
        chk("t4_valid_R2", bus.out_valid, 0);
        go();
        chk("t4_valid_R3", bus.out_valid, 1);
        chk("t4_pc_R3",    bus.out_pc,    5);
        chk("t4_ins_R3",   bus.out_instr, 32'h1000_0005);

        // halt with a full queue
        start(1'b0);
        @(negedge clock);
        go();
        go();
        step();
        bus.halt      = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clock);
        chk("t5_rd_en_c3",  bus.imem_rd_en, 0);
        chk("t5_halted_c3", bus.halted,     0);
        go();
        chk("t5_pc_c4",     bus.out_pc, 1);
        chk("t5_halted_c4", bus.halted, 0);
        go();
        chk("t5_halted_c5", bus.halted,    1);
        chk("t5_valid_c5",  bus.out_valid, 0);
        step();
        bus.halt = 1'b0;
        @(negedge clock);
        chk("t5_rd_en_c6", bus.imem_rd_en, 1);
        chk("t5_addr_c6",  bus.imem_addr,  2);
        go();
        go();
        chk("t5_pc_c8", bus.out_pc, 2);

        // reset mid-stream
        start(1'b1);
        @(negedge clock);
        go();
        go();
        go();
        step();
        reset = 1'b1;
        @(negedge clock);
        chk("t6_rd_en_rst", bus.imem_rd_en, 0);
        step();
        @(negedge clock);
        chk("t6_valid_after", bus.out_valid,  0);
        chk("t6_rd_en_after", bus.imem_rd_en, 0);
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("t6_addr_rel", bus.imem_addr, 0);
        go();
        go();
        chk("t6_pc_first", bus.out_pc, 0);

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            step();
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) bus.halt = !bus.halt;
            bus.redirect_valid = ($urandom_range(0, 24) == 0);
            bus.redirect_pc    = 5'($urandom_range(0, 31));
            reset              = ($urandom_range(0, 99) == 0);
        end
        step();
        reset              = 1'b0;
        bus.halt           = 1'b0;
        bus.redirect_valid = 1'b0;
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
